vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

- Generates 640x480@60 Hz VGA timing from the 100 MHz system clock.
- Produces the `hc`/`vc` pixel coordinates, the `dat_act` active-video flag and the `hsync`/`vsync` pins that the game and picture-display logic consume.
- Sits between the board clock and every pixel-drawing block. It is the single source of the scan position, so drawing logic no longer keeps its own counters or clock divider.
- Optionally drives a built-in colour-bar test pattern for board bring-up.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate). Allowed range 1..16.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `SYNC_POL`, 0: sync asserted level. 0 = active-low, 1 = active-high.

Ports:
- `clk` input 1: system clock, 100 MHz. This is the only clock.
- `reset` input 1: synchronous, active-high.
- `pix_en` output 1: one-`clk` strobe. High in the cycle before each coordinate advance.
- `hc` output 10: horizontal position, 0..H_TOTAL-1.
- `vc` output 10: vertical position, 0..V_TOTAL-1.
- `dat_act` output 1: high when `hc < H_ACTIVE` and `vc < V_ACTIVE`.
- `hsync` output 1: horizontal sync, polarity set by `SYNC_POL`.
- `vsync` output 1: vertical sync, polarity set by `SYNC_POL`.
- `frame_start` output 1: one-`clk` pulse when the coordinates become (0,0).
- `rgb` output 12: test-pattern colour, {R[3:0],G[3:0],B[3:0]}.

## Operation
Derived constants:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Both must be ≤ 1024. Elaboration fails otherwise.

Divider:
- `div_cnt` counts 0..CLK_DIV-1 every `clk`, then wraps to 0.
- `pix_en` is a decode of the `div_cnt` register: `pix_en = (div_cnt == CLK_DIV-1)`.
- With CLK_DIV = 1, `pix_en` is constantly high outside reset.

Coordinate counters (update only on edges where `pix_en` = 1):
- `hc` increments by 1.
- At `hc` = H_TOTAL-1, `hc` wraps to 0 and `vc` increments.
- At `vc` = V_TOTAL-1 together with the `hc` wrap, `vc` wraps to 0.

Derived outputs (registered; computed from the next counter values so they are cycle-aligned with `hc`/`vc`):
- `hsync` is asserted when H_ACTIVE+H_FP ≤ `hc` < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- `vsync` is asserted when V_ACTIVE+V_FP ≤ `vc` < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- `frame_start` is high for exactly one `clk`, in the cycle where `hc`=0 and `vc`=0 first appear.

Reset values (apply one cycle after `reset` is sampled high, whatever the current position):
- `div_cnt` = 0, `pix_en` = 0.
- `hc` = H_TOTAL-1, `vc` = V_TOTAL-1.
- `dat_act` = 0, `frame_start` = 0, `rgb` = 0.
- `hsync` and `vsync` inactive, i.e. `~SYNC_POL`.
- This position lies in blanking, so every output is consistent with the counters. The first advance after reset lands on (0,0) and fires `frame_start`.

## Timing
- Reset release: `pix_en` is high in the 4th cycle after release (CLK_DIV = 4). On the following edge `hc`/`vc` become 0/0, and `frame_start`=1 and `dat_act`=1 in that same cycle.
- Each coordinate value is held for CLK_DIV `clk` cycles.
- Line = 800 pixels = 3200 `clk`. Frame = 420 000 pixels = 1 680 000 `clk`.
- `hsync`, `vsync`, `dat_act` and `rgb` change on the same edge as `hc`/`vc`. There is zero pipeline skew between them.
- Consumers sample the coordinates on any `clk` edge. A new value is guaranteed on the edge that follows a `pix_en` cycle.

## Configuration
Macro: `VGA_TEST_PATTERN_EN`.
- Defined: `rgb` shows eight vertical bars, each H_ACTIVE/8 = 80 px wide. Bar index = `hc`/80, giving colours 12'hFFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000 in order. `rgb` = 0 whenever `dat_act` = 0. `rgb` is registered and aligned with `hc`.
- Undefined: `rgb` is tied to 12'h000, and no pattern logic is synthesised.

## Test plan
- Reset release → `pix_en` high in cycle 4. On the next edge, `hc`=0, `vc`=0, `frame_start`=1 for one cycle, `dat_act`=1, `hsync`=1, `vsync`=1.
- Run one line → `dat_act` high for `hc` 0..639. `hsync` low for `hc` 656..751, i.e. 384 `clk`. `hc` wraps 799→0 and `vc` goes 0→1, 3200 `clk` after the line start.
- Run a full frame → `vsync` low while `vc` is 490..491. `vc` wraps 524→0, and `frame_start` pulses exactly 1 680 000 `clk` apart.
- Assert `reset` for one cycle at `hc`=300, `vc`=200 → next cycle `hc`=799, `vc`=524, `dat_act`=0, `hsync`=1, `vsync`=1, `pix_en`=0. The counters then restart as in the reset-release test.
- With `VGA_TEST_PATTERN_EN` defined → (`hc`=85, `vc`=10) gives `rgb`=12'hFF0, (639, 479) gives 12'h000, and (700, 10) gives 0. With the macro undefined, `rgb`=0 throughout.
- With CLK_DIV=1 → `pix_en` is constantly high, `hc` advances every `clk`, and a line lasts 800 `clk`.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA scan timing (default 640x480@60 from 100 MHz) with optional colour bars.
//   Optional feature macro: VGA_TEST_PATTERN_EN (colour-bar test pattern on rgb).
//   Ports:
//     clk         system clock, the only clock
//     reset       synchronous, active-high
//     pix_en      one-clk strobe in the cycle before each coordinate advance
//     hc, vc      scan position, 0..H_TOTAL-1 / 0..V_TOTAL-1
//     dat_act     high inside the visible area
//     hsync/vsync sync pulses, asserted level set by SYNC_POL
//     frame_start one-clk pulse when the position becomes (0,0)
//     rgb         test-pattern colour {R,G,B} x 4 bits, 0 when the pattern is compiled out
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pix_en,
  output logic [9:0]  hc,
  output logic [9:0]  vc,
  output logic        dat_act,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [11:0] rgb
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be in 1..16");
  end
  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [10:0] HA       = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VA       = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  logic [3:0] div_q, div_d;
  logic       pix_en_q, pix_en_d;
  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic       act_q, act_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic       h_wrap;
  // Syncs, active flag and frame pulse are computed from the next counter
  // values so that, once registered, they line up with hc/vc on the same edge.
  always_comb begin
    div_d    = div_q == DIV_LAST ? 4'd0 : div_q + 4'd1;
    pix_en_d = div_d == DIV_LAST;
    h_wrap   = hc_q == H_LAST;
    hc_d     = !pix_en_q ? hc_q : h_wrap ? 10'd0 : hc_q + 10'd1;
    vc_d     = !(pix_en_q && h_wrap) ? vc_q : vc_q == V_LAST ? 10'd0 : vc_q + 10'd1;
    act_d    = {1'b0, hc_d} < HA && {1'b0, vc_d} < VA;
    hs_d     = ({1'b0, hc_d} >= HS_BEG && {1'b0, hc_d} < HS_END) ? SYNC_POL : ~SYNC_POL;
    vs_d     = ({1'b0, vc_d} >= VS_BEG && {1'b0, vc_d} < VS_END) ? SYNC_POL : ~SYNC_POL;
    fs_d     = pix_en_q && hc_d == 10'd0 && vc_d == 10'd0;
  end
  // Reset parks the scan on the last blanking position so the first advance
  // lands on (0,0) and raises frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= 4'd0;
      pix_en_q <= 1'b0;
      hc_q     <= H_LAST;
      vc_q     <= V_LAST;
      act_q    <= 1'b0;
      hs_q     <= ~SYNC_POL;
      vs_q     <= ~SYNC_POL;
      fs_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      act_q    <= act_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      fs_q     <= fs_d;
    end
  end
  assign pix_en      = pix_en_q;
  assign hc          = hc_q;
  assign vc          = vc_q;
  assign dat_act     = act_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
  logic [11:0] rgb_q, rgb_d;
  logic [2:0]  bar;
  // Bar order FFF,FF0,0FF,0F0,F0F,F00,00F,000: each channel is on when one
  // bit of the bar index is clear (R:bit1, G:bit2, B:bit0).
  always_comb begin
    bar   = 3'(hc_d / BAR_W);
    rgb_d = act_d ? {{4{~bar[1]}}, {4{~bar[2]}}, {4{~bar[0]}}} : 12'h000;
  end
  always_ff @(posedge clk) begin
    if (reset) rgb_q <= 12'h000;
    else rgb_q <= rgb_d;
  end
  assign rgb = rgb_q;
`else
  assign rgb = 12'h000;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of vga_timing_gen at default timing and at CLK_DIV=1 with a short frame.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic a_pix, a_act, a_hs, a_vs, a_fs;
  logic [9:0] a_hc, a_vc;
  logic [11:0] a_rgb;
  logic b_pix, b_act, b_hs, b_vs, b_fs;
  logic [9:0] b_hc, b_vc;
  logic [11:0] b_rgb;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  vga_timing_gen u_a (
    .clk(clk), .reset(rst_a), .pix_en(a_pix), .hc(a_hc), .vc(a_vc), .dat_act(a_act),
    .hsync(a_hs), .vsync(a_vs), .frame_start(a_fs), .rgb(a_rgb)
  );
  vga_timing_gen #(
    .CLK_DIV(1), .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
  ) u_b (
    .clk(clk), .reset(rst_b), .pix_en(b_pix), .hc(b_hc), .vc(b_vc), .dat_act(b_act),
    .hsync(b_hs), .vsync(b_vs), .frame_start(b_fs), .rgb(b_rgb)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [11:0] exp_rgb(int h, int v, int va);
    if (h >= 640 || v >= va) return 12'h000;
`ifdef VGA_TEST_PATTERN_EN
    case (h / 80)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
`else
    return 12'h000;
`endif
  endfunction
  initial begin
    int n_act, n_hs, e_act, e_hs, e_rgb, e_pix, e_step, e_vs, n_vs, n_fs;
    int prev;
    logic found;
    logic [11:0] r85, r639, r700;
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    check("a_rst_hc", 32'(a_hc), 799);
    check("a_rst_vc", 32'(a_vc), 524);
    check("a_rst_pix", 32'(a_pix), 0);
    check("a_rst_act", 32'(a_act), 0);
    check("a_rst_hs", 32'(a_hs), 1);
    check("a_rst_vs", 32'(a_vs), 1);
    check("a_rst_fs", 32'(a_fs), 0);
    check("a_rst_rgb", 32'(a_rgb), 0);
    rst_a = 1'b0;
    tick();
    check("a_pix_c2", 32'(a_pix), 0);
    tick();
    check("a_pix_c3", 32'(a_pix), 0);
    tick();
    check("a_pix_c4", 32'(a_pix), 1);
    check("a_hc_c4", 32'(a_hc), 799);
    tick();
    check("a_start_hc", 32'(a_hc), 0);
    check("a_start_vc", 32'(a_vc), 0);
    check("a_start_fs", 32'(a_fs), 1);
    check("a_start_act", 32'(a_act), 1);
    check("a_start_hs", 32'(a_hs), 1);
    check("a_start_vs", 32'(a_vs), 1);
    check("a_start_pix", 32'(a_pix), 0);
    n_act = 0; n_hs = 0; e_act = 0; e_hs = 0; e_rgb = 0; e_pix = 0;
    r85 = 12'hxxx; r639 = 12'hxxx; r700 = 12'hxxx;
    for (int t = 0; t < 3200; t++) begin
      if (t > 0) tick();
      if (t == 1) check("a_fs_once", 32'(a_fs), 0);
      n_act += int'(a_act);
      n_hs += int'(!a_hs);
      if (a_act !== (a_hc < 640 && a_vc < 480)) e_act++;
      if (a_hs !== !(a_hc >= 656 && a_hc < 752)) e_hs++;
      if (a_rgb !== exp_rgb(int'(a_hc), int'(a_vc), 480)) e_rgb++;
      if (a_pix !== (t % 4 == 3)) e_pix++;
      if (a_hc == 85) r85 = a_rgb;
      if (a_hc == 639) r639 = a_rgb;
      if (a_hc == 700) r700 = a_rgb;
    end
    check("a_line_act_clk", 32'(n_act), 2560);
    check("a_line_hs_clk", 32'(n_hs), 384);
    check("a_act_align", 32'(e_act), 0);
    check("a_hs_align", 32'(e_hs), 0);
    check("a_rgb_line", 32'(e_rgb), 0);
    check("a_pix_period", 32'(e_pix), 0);
    check("a_rgb_85", 32'(r85), 32'(exp_rgb(85, 0, 480)));
    check("a_rgb_639", 32'(r639), 32'(exp_rgb(639, 0, 480)));
    check("a_rgb_700", 32'(r700), 32'(exp_rgb(700, 0, 480)));
    check("a_end_hc", 32'(a_hc), 799);
    check("a_end_vc", 32'(a_vc), 0);
    tick();
    check("a_wrap_hc", 32'(a_hc), 0);
    check("a_wrap_vc", 32'(a_vc), 1);
    check("a_wrap_fs", 32'(a_fs), 0);
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      tick();
      if (a_hc == 300) found = 1'b1;
    end
    check("a_reach_300", 32'(found), 1);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("a_rr_hc", 32'(a_hc), 799);
    check("a_rr_vc", 32'(a_vc), 524);
    check("a_rr_act", 32'(a_act), 0);
    check("a_rr_hs", 32'(a_hs), 1);
    check("a_rr_vs", 32'(a_vs), 1);
    check("a_rr_pix", 32'(a_pix), 0);
    tick();
    tick();
    tick();
    check("a_rr_pix_c4", 32'(a_pix), 1);
    tick();
    check("a_rr_hc0", 32'(a_hc), 0);
    check("a_rr_vc0", 32'(a_vc), 0);
    check("a_rr_fs", 32'(a_fs), 1);
    check("b_rst_hc", 32'(b_hc), 799);
    check("b_rst_vc", 32'(b_vc), 26);
    check("b_rst_pix", 32'(b_pix), 0);
    check("b_rst_hs", 32'(b_hs), 0);
    check("b_rst_vs", 32'(b_vs), 0);
    rst_b = 1'b0;
    tick();
    check("b_pix_c1", 32'(b_pix), 1);
    check("b_hc_c1", 32'(b_hc), 799);
    tick();
    check("b_start_hc", 32'(b_hc), 0);
    check("b_start_vc", 32'(b_vc), 0);
    check("b_start_fs", 32'(b_fs), 1);
    check("b_start_vs", 32'(b_vs), 0);
    e_pix = 0; e_step = 0; e_vs = 0; n_vs = 0; n_fs = 0; e_rgb = 0;
    for (int i = 1; i <= 21600; i++) begin
      prev = int'(b_hc);
      tick();
      if (b_pix !== 1'b1) e_pix++;
      if (int'(b_hc) != (prev == 799 ? 0 : prev + 1)) e_step++;
      n_vs += int'(b_vs);
      if (b_vs !== (b_vc >= 22 && b_vc < 24)) e_vs++;
      if (b_rgb !== exp_rgb(int'(b_hc), int'(b_vc), 20)) e_rgb++;
      if (i < 21600) n_fs += int'(b_fs);
      if (i == 800) begin
        check("b_line_hc", 32'(b_hc), 0);
        check("b_line_vc", 32'(b_vc), 1);
      end
      if (i == 21599) begin
        check("b_last_hc", 32'(b_hc), 799);
        check("b_last_vc", 32'(b_vc), 26);
      end
      if (i == 21600) begin
        check("b_frame_fs", 32'(b_fs), 1);
        check("b_frame_hc", 32'(b_hc), 0);
        check("b_frame_vc", 32'(b_vc), 0);
      end
    end
    check("b_pix_const", 32'(e_pix), 0);
    check("b_hc_step", 32'(e_step), 0);
    check("b_vs_clk", 32'(n_vs), 1600);
    check("b_vs_align", 32'(e_vs), 0);
    check("b_fs_mid", 32'(n_fs), 0);
    check("b_rgb_frame", 32'(e_rgb), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
